if_fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the program counter and drives a single-outstanding-request valid/ready instruction-memory port. It also holds a one-entry fetch buffer whose contents are presented to IF/ID as Instr_IF / PCplus4_IF. It honours the hazard unit's Stall, accepts branch/jump redirects from ID, and emits NOP (32'h0000_0000) whenever no fetched instruction is available.

---
 rtl/if_fetch_unit_pkg.sv | 35 +++
 rtl/if_fetch_unit_if.sv | 38 +++
 rtl/if_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared types and defaults for the instruction-fetch stage.
// Optional feature macro used by the fetch unit: IF_FETCH_PERF_EN.
package if_fetch_unit_pkg;

   // Width of one instruction word and of every address in the fetch stage.
   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   // Word driven to IF/ID when no fetched instruction is available.
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   // First fetch address after reset.
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch FSM states:
   //   S_REQ     - may issue a request when the buffer will be free
   //   S_WAIT    - one request outstanding, response will be kept
   //   S_DISCARD - one request outstanding, response will be dropped
   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   // Sequential next word address; wraps modulo 2^32.
   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
      return pc + 32'd4;
   endfunction

   // Redirect targets are forced onto a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory port of the fetch stage.
//
// Handshake rules:
//   - Request: a transfer happens on a rising edge where imem_req_valid and
//     imem_req_ready are both high. imem_addr is stable while imem_req_valid
//     is high and ready is low. The fetch unit never has more than one
//     accepted request outstanding.
//   - Response: imem_resp_valid is a single-cycle pulse carrying
//     imem_resp_data for the oldest outstanding request; there is no
//     backpressure, the fetch unit always takes (or drops) it.
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic                 imem_req_valid;
   logic                 imem_req_ready;
   logic [ADDR_W-1:0]    imem_addr;
   logic                 imem_resp_valid;
   logic [INSTR_W-1:0]   imem_resp_data;

   // Fetch unit side.
   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   // Instruction memory side.
   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues single-outstanding fetches, keeps a one-entry fetch
// buffer and presents NOP when that buffer is empty.
// Optional macro IF_FETCH_PERF_EN adds bubble_cnt / discard_cnt outputs.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Stall,
   input  logic                 Redirect,
   input  logic [ADDR_W-1:0]    RedirectPC,
   if_fetch_unit_if.master      imem,
   output logic [INSTR_W-1:0]   Instr_IF,
   output logic [ADDR_W-1:0]    PCplus4_IF,
   output logic                 FetchValid,
   output fetch_state_t         state_dbg
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]          bubble_cnt,
   output logic [31:0]          discard_cnt
`endif
);

   fetch_state_t        state;
   fetch_state_t        state_nxt;

   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   req_pc;
   logic                buf_valid;
   logic [INSTR_W-1:0]  buf_instr;
   logic [ADDR_W-1:0]   buf_pc4;

   logic                consume;
   logic                req_fire;
   logic                resp_keep;

   // IF/ID takes the buffered word this cycle; a redirect squashes it instead.
   assign consume   = buf_valid && !Stall && !Redirect;
   assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
   // Only a response seen in S_WAIT without a same-cycle redirect is kept.
   assign resp_keep = (state == S_WAIT) && imem.imem_resp_valid && !Redirect;

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a redirect turns a pending response into one to drop.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_REQ: begin
            if (!Redirect && req_fire) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_resp_valid) begin
               state_nxt = S_REQ;
            end else if (Redirect) begin
               state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem.imem_resp_valid) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   // Request outputs: issue only when the buffer is free by the next edge.
   always_comb begin
      imem.imem_req_valid = 1'b0;
      imem.imem_addr      = pc;
      if ((state == S_REQ) && !Rst && !Redirect) begin
         imem.imem_req_valid = !buf_valid || consume;
      end
   end

   // PC, outstanding-request address and fetch buffer.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pc        <= RESET_PC;
         req_pc    <= RESET_PC;
         buf_valid <= 1'b0;
         buf_instr <= NOP_INSTR;
         buf_pc4   <= '0;
      end else if (Redirect) begin
         // Redirect squashes the buffer and retargets the PC; any outstanding
         // response is dropped by the FSM.
         pc        <= word_align(RedirectPC);
         buf_valid <= 1'b0;
      end else begin
         if (req_fire) begin
            req_pc <= pc;
            pc     <= pc_next(pc);
         end
         // A request is only issued when the buffer empties, so a kept
         // response never collides with a valid entry.
         if (resp_keep) begin
            buf_instr <= imem.imem_resp_data;
            buf_pc4   <= pc_next(req_pc);
            buf_valid <= 1'b1;
         end else if (consume) begin
            buf_valid <= 1'b0;
         end
      end
   end

   // IF/ID-facing outputs, NOP when nothing has been fetched.
   always_comb begin
      Instr_IF   = buf_valid ? buf_instr : NOP_INSTR;
      PCplus4_IF = buf_valid ? buf_pc4 : '0;
      FetchValid = buf_valid;
      state_dbg  = state;
   end

`ifdef IF_FETCH_PERF_EN
   logic resp_drop;

   // Any response arriving in S_DISCARD, or in S_WAIT alongside a redirect.
   assign resp_drop = imem.imem_resp_valid &&
                      ((state == S_DISCARD) || ((state == S_WAIT) && Redirect));

   // Bubble and dropped-response counters; both wrap at 2^32.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         bubble_cnt  <= '0;
         discard_cnt <= '0;
      end else begin
         if (!Stall && !buf_valid) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
         if (resp_drop) begin
            discard_cnt <= discard_cnt + 32'd1;
         end
      end
   end
`else
   // Counters not built; the fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: bench for if_fetch_unit with a behavioural instruction
// memory that returns the request address as the instruction word.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   // ---------------- clock / reset ----------------
   logic        Clk        = 1'b0;
   logic        Rst        = 1'b1;
   logic        Stall      = 1'b0;
   logic        Redirect   = 1'b0;
   logic [31:0] RedirectPC = 32'h0;

   always #5 Clk = ~Clk;

   logic [31:0]  Instr_IF;
   logic [31:0]  PCplus4_IF;
   logic         FetchValid;
   fetch_state_t state_dbg;
`ifdef IF_FETCH_PERF_EN
   logic [31:0]  bubble_cnt;
   logic [31:0]  discard_cnt;
`endif

   if_fetch_unit_if bus();

   if_fetch_unit dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Stall      (Stall),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC),
      .imem       (bus),
      .Instr_IF   (Instr_IF),
      .PCplus4_IF (PCplus4_IF),
      .FetchValid (FetchValid),
      .state_dbg  (state_dbg)
`ifdef IF_FETCH_PERF_EN
      ,
      .bubble_cnt (bubble_cnt),
      .discard_cnt(discard_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check32(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic check_st(input string name, input fetch_state_t exp);
      check32(name, {30'b0, state_dbg}, {30'b0, exp});
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // ---------------- memory model ----------------
   logic        mem_ready      = 1'b1;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data  = 32'h0;
   int          resp_delay     = 1;
   bit          hs_seen        = 1'b0;
   bit          rst_seen       = 1'b0;
   logic [31:0] hs_addr        = 32'h0;
   bit          mem_busy       = 1'b0;
   int          mem_cnt        = 0;
   logic [31:0] mem_addr_q     = 32'h0;

   assign bus.imem_req_ready  = mem_ready;
   assign bus.imem_resp_valid = mem_resp_valid;
   assign bus.imem_resp_data  = mem_resp_data;

   // Response pulse resp_delay cycles after an accepted request; aborts on Rst.
   always @(posedge Clk) begin
      #1;
      mem_resp_valid = 1'b0;
      if (rst_seen) begin
         mem_busy = 1'b0;
      end else begin
         if (hs_seen) begin
            mem_busy   = 1'b1;
            mem_cnt    = resp_delay;
            mem_addr_q = hs_addr;
         end
         if (mem_busy) begin
            if (mem_cnt <= 1) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_addr_q;
               mem_busy       = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   logic [31:0] exp_pc     = 32'h0;
   int          exp_bubble = 0;

   always @(negedge Clk) begin
      rst_seen = Rst;
      hs_seen  = 1'b0;
      if (Rst) begin
         exp_q.delete();
         exp_pc = RESET_PC_DEFAULT;
      end else begin
         if (!Stall && !FetchValid) exp_bubble++;
         if (FetchValid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_empty: FetchValid=1 Instr_IF=%h with no fetch expected", Instr_IF);
            end else begin
               check32("sb_instr", Instr_IF, exp_q[0][63:32]);
               check32("sb_pc4", PCplus4_IF, exp_q[0][31:0]);
               if (!Stall && !Redirect) void'(exp_q.pop_front());
            end
            if (Stall) check1("sb_stall_no_req", bus.imem_req_valid, 1'b0);
         end else begin
            check32("sb_nop_instr", Instr_IF, NOP_INSTR_DEFAULT);
            check32("sb_nop_pc4", PCplus4_IF, 32'h0);
         end
         if (Redirect) begin
            check1("sb_redirect_gates_req", bus.imem_req_valid, 1'b0);
            exp_q.delete();
            exp_pc = {RedirectPC[31:2], 2'b00};
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            hs_seen = 1'b1;
            hs_addr = bus.imem_addr;
            check32("sb_req_addr", bus.imem_addr, exp_pc);
            exp_q.push_back({bus.imem_addr, bus.imem_addr + 32'd4});
            exp_pc = exp_pc + 32'd4;
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic         stall;
      logic         redir;
      logic [31:0]  rpc;
      logic         exp_rv;
      logic [31:0]  exp_addr;
      logic         exp_fv;
      logic [31:0]  exp_instr;
      logic [31:0]  exp_pc4;
      fetch_state_t exp_st;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs[NVEC];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      logic [31:0] hold_addr;

      //              stall redir rpc           rv   addr          fv   instr         pc4           state
      vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        S_REQ};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        S_WAIT};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4,        1'b1, 32'h0,        32'h4,        S_REQ};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        S_WAIT};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        S_REQ};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        S_REQ};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        S_REQ};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        1'b1, 32'h4,        32'h8,        S_REQ};
      vecs[8]  = '{1'b0, 1'b1, 32'h107,       1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        S_WAIT};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h104,      1'b0, 32'h0,        32'h0,        S_REQ};
      vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        S_WAIT};
      vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h108,      1'b1, 32'h104,      32'h108,      S_REQ};

      // Reset state, held for three edges.
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check1("rst_req_valid", bus.imem_req_valid, 1'b0);
      check1("rst_fetch_valid", FetchValid, 1'b0);
      check32("rst_instr", Instr_IF, NOP_INSTR_DEFAULT);
      check32("rst_pc4", PCplus4_IF, 32'h0);
      check_st("rst_state", S_REQ);

      // Zero-wait run, 3-cycle stall, same-cycle redirect + response.
      for (int i = 0; i < NVEC; i++) begin
         tick();
         Rst        = 1'b0;
         Stall      = vecs[i].stall;
         Redirect   = vecs[i].redir;
         RedirectPC = vecs[i].rpc;
         if (i == NVEC - 1) resp_delay = 3;
         @(negedge Clk);
         check1($sformatf("vec%0d_req_valid", i), bus.imem_req_valid, vecs[i].exp_rv);
         if (vecs[i].exp_rv) check32($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
         check1($sformatf("vec%0d_fetch_valid", i), FetchValid, vecs[i].exp_fv);
         check32($sformatf("vec%0d_instr", i), Instr_IF, vecs[i].exp_instr);
         check32($sformatf("vec%0d_pc4", i), PCplus4_IF, vecs[i].exp_pc4);
         check_st($sformatf("vec%0d_state", i), vecs[i].exp_st);
      end
`ifdef IF_FETCH_PERF_EN
      check32("perf_discard_after_same_cycle", discard_cnt, 32'd1);
`endif

      // Redirect to 0x100 while waiting (slow memory) for 0x108.
      tick();
      Redirect   = 1'b1;
      RedirectPC = 32'h100;
      @(negedge Clk);
      check_st("redir_wait_state", S_WAIT);
      check1("redir_wait_no_resp", bus.imem_resp_valid, 1'b0);
      tick();
      Redirect = 1'b0;
      @(negedge Clk);
      check_st("redir_discard_state", S_DISCARD);
      check1("redir_discard_no_req", bus.imem_req_valid, 1'b0);
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         tick();
         @(negedge Clk);
         if (bus.imem_req_valid) ok = 1'b1;
         else check1("redir_fv_low", FetchValid, 1'b0);
      end
      check1("redir_req_seen", ok, 1'b1);
      check32("redir_req_addr", bus.imem_addr, 32'h100);
      resp_delay = 1;
`ifdef IF_FETCH_PERF_EN
      check32("perf_discard_after_wait_redirect", discard_cnt, 32'd2);
`endif
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         tick();
         @(negedge Clk);
         if (FetchValid) ok = 1'b1;
      end
      check1("redir_fetch_seen", ok, 1'b1);
      check32("redir_instr", Instr_IF, 32'h100);
      check32("redir_pc4", PCplus4_IF, 32'h104);

      // Request for 0x104 accepted at this edge; then 4 cycles of ready low.
      tick();
      @(negedge Clk);
      tick();
      mem_ready = 1'b0;
      @(negedge Clk);
      check32("rdy_instr", Instr_IF, 32'h104);
      check1("rdy_req_valid0", bus.imem_req_valid, 1'b1);
      hold_addr = bus.imem_addr;
      check32("rdy_addr0", hold_addr, 32'h108);
      for (int k = 1; k < 4; k++) begin
         tick();
         @(negedge Clk);
         check1($sformatf("rdy_req_valid%0d", k), bus.imem_req_valid, 1'b1);
         check32($sformatf("rdy_addr%0d", k), bus.imem_addr, hold_addr);
      end
      tick();
      mem_ready = 1'b1;
      @(negedge Clk);
      check32("rdy_addr_release", bus.imem_addr, hold_addr);
      tick();
      @(negedge Clk);
      tick();
      @(negedge Clk);
      check32("rdy_next_instr", Instr_IF, 32'h108);
      check32("rdy_next_addr", bus.imem_addr, 32'h10C);

      // Wrap: fetch 0xFFFF_FFFC (target low bits ignored).
      tick();
      Redirect   = 1'b1;
      RedirectPC = 32'hFFFF_FFFE;
      @(negedge Clk);
      tick();
      Redirect = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(negedge Clk);
         if (FetchValid) ok = 1'b1;
         else tick();
      end
      check1("wrap_fetch_seen", ok, 1'b1);
      check32("wrap_instr", Instr_IF, 32'hFFFF_FFFC);
      check32("wrap_pc4", PCplus4_IF, 32'h0);
      check1("wrap_req_valid", bus.imem_req_valid, 1'b1);
      check32("wrap_next_addr", bus.imem_addr, 32'h0);

      tick();
`ifdef IF_FETCH_PERF_EN
      // Drops: same-cycle redirect, redirect while waiting, wrap redirect.
      check32("perf_discard_final", discard_cnt, 32'd3);
      check32("perf_bubble_final", bubble_cnt, exp_bubble);
`endif
      check32("sb_queue_depth", exp_q.size(), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
